// File: rtl/dkong3_objdma_ctrl.sv
// Sprite object DMA: on vblank start, if armed, borrows the CPU bus and copies LEN
// bytes from SRC_BASE into object RAM, two CE slots per byte (read, then write).
//
// state  | meaning
// IDLE   | waiting for an armed vblank start
// REQ    | bus requested, waiting for grant
// RD     | source byte on the CPU bus
// WR     | byte written into object RAM
// REL    | bus released, completion pulse
module dkong3_objdma_ctrl #(
    parameter logic [15:0] SRC_BASE = 16'h7000,
    parameter int          LEN      = 384
) (
    input  logic        I_CLK_24M,
    input  logic        I_RST,
    input  logic        I_CE,
    input  logic        I_ARM,
    input  logic        I_VBLANKn,
    input  logic        I_BUSAK_n,
    input  logic [7:0]  I_SRC_D,
    output logic        O_BUSRQ_n,
    output logic [15:0] O_SRC_A,
    output logic        O_SRC_RDn,
    output logic [9:0]  O_DMAD_A,
    output logic [7:0]  O_DMAD_D,
    output logic        O_DMAD_CE,
    output logic        O_BUSY,
    output logic        O_DONE
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_REL} state_t;

    localparam logic [10:0] LAST = 11'(LEN - 1);

    state_t      r_state;
    logic        r_vbl_d;
    logic        r_start;
    logic        r_pend;
    logic [10:0] r_cnt;
    logic [7:0]  r_data;
    logic [9:0]  r_dmad_a;
    logic [15:0] r_src_a;
    logic        r_src_rdn;
    logic        r_busrq_n;
    logic        r_done;

    logic        w_vbl_fall;
    logic        w_go;
    logic [10:0] w_cnt_inc;

    // Edge detect runs every clock so a vblank falling between CE slots is not missed.
    assign w_vbl_fall = r_vbl_d & ~I_VBLANKn;
    assign w_go       = I_CE & r_start & r_pend & (r_state == S_IDLE);
    assign w_cnt_inc  = r_cnt + 11'd1;

    always_ff @(posedge I_CLK_24M or posedge I_RST) begin
        if (I_RST) begin
            r_state   <= S_IDLE;
            r_vbl_d   <= 1'b1;
            r_start   <= 1'b0;
            r_pend    <= 1'b0;
            r_cnt     <= 11'd0;
            r_data    <= 8'd0;
            r_dmad_a  <= 10'd0;
            r_src_a   <= 16'd0;
            r_src_rdn <= 1'b1;
            r_busrq_n <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_vbl_d <= I_VBLANKn;

            // A start request is consumed by the next CE whether or not it is used.
            if (w_vbl_fall)
                r_start <= 1'b1;
            else if (I_CE)
                r_start <= 1'b0;

            if (I_ARM)
                r_pend <= 1'b1;
            else if (w_go)
                r_pend <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state   <= S_REQ;
                        r_cnt     <= 11'd0;
                        r_busrq_n <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (I_CE && !I_BUSAK_n) begin
                        r_state   <= S_RD;
                        r_src_rdn <= 1'b0;
                        r_src_a   <= SRC_BASE + {5'd0, r_cnt};
                    end
                end
                S_RD: begin
                    if (I_CE) begin
                        r_state   <= S_WR;
                        r_src_rdn <= 1'b1;
                        r_data    <= I_SRC_D;
                        r_dmad_a  <= r_cnt[9:0];
                    end
                end
                S_WR: begin
                    if (I_CE) begin
                        if (r_cnt == LAST) begin
                            r_state   <= S_REL;
                            r_busrq_n <= 1'b1;
                            r_done    <= 1'b1;
                        end else begin
                            r_state   <= S_RD;
                            r_cnt     <= w_cnt_inc;
                            r_src_rdn <= 1'b0;
                            r_src_a   <= SRC_BASE + {5'd0, w_cnt_inc};
                        end
                    end
                end
                S_REL: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign O_BUSRQ_n = r_busrq_n;
    assign O_SRC_A   = r_src_a;
    assign O_SRC_RDn = r_src_rdn;
    assign O_DMAD_A  = r_dmad_a;
    assign O_DMAD_D  = r_data;
    // Write strobe is qualified by CE so object RAM sees one write per WR slot.
    assign O_DMAD_CE = (r_state == S_WR) & I_CE;
    assign O_BUSY    = (r_state != S_IDLE);
    assign O_DONE    = r_done;

endmodule
